// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write bypass, per-register busy scoreboard
// and a rising-edge trigger that writes 1 into a fixed register.
module regfile_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int TRIGGER_REG   = 5,
  parameter int OBS_REG       = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] AD1_i,
  input  logic [ADDRESS_WIDTH-1:0] AD2_i,
  input  logic [ADDRESS_WIDTH-1:0] AD3_i,
  input  logic                     WE3_i,
  input  logic [DATA_WIDTH-1:0]    WD3_i,
  input  logic                     ISS_i,
  input  logic [ADDRESS_WIDTH-1:0] ISS_RD_i,
  input  logic                     TRIGGER_i,
  output logic [DATA_WIDTH-1:0]    RD1_o,
  output logic [DATA_WIDTH-1:0]    RD2_o,
  output logic                     BUSY1_o,
  output logic                     BUSY2_o,
  output logic [DATA_WIDTH-1:0]    a0_o
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] TRIG_ADDR = ADDRESS_WIDTH'(TRIGGER_REG);
  localparam logic [ADDRESS_WIDTH-1:0] OBS_ADDR  = ADDRESS_WIDTH'(OBS_REG);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  trig_q;
  logic                  wr_en;
  logic                  iss_en;
  logic                  trig_fire;

  assign wr_en     = WE3_i && (AD3_i != '0);
  assign iss_en    = ISS_i && (ISS_RD_i != '0);
  assign trig_fire = TRIGGER_i && !trig_q && (TRIG_ADDR != '0);

  // Statement order sets priority: issue beats writeback on busy,
  // trigger beats writeback on data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy   <= '0;
      trig_q <= 1'b0;
    end else begin
      trig_q <= TRIGGER_i;
      if (wr_en) begin
        regs[AD3_i] <= WD3_i;
        busy[AD3_i] <= 1'b0;
      end
      if (iss_en) busy[ISS_RD_i] <= 1'b1;
      if (trig_fire) regs[TRIG_ADDR] <= DATA_WIDTH'(1);
    end
  end

  assign RD1_o = (AD1_i == '0) ? '0 :
                 (wr_en && (AD1_i == AD3_i)) ? WD3_i : regs[AD1_i];
  assign RD2_o = (AD2_i == '0) ? '0 :
                 (wr_en && (AD2_i == AD3_i)) ? WD3_i : regs[AD2_i];

  assign BUSY1_o = (AD1_i != '0) && busy[AD1_i] && !(WE3_i && (AD3_i == AD1_i));
  assign BUSY2_o = (AD2_i != '0) && busy[AD2_i] && !(WE3_i && (AD3_i == AD2_i));

  assign a0_o = regs[OBS_ADDR];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table of per-cycle vectors for regfile_scoreboard plus hand
// sequences for reset-during-busy and trigger-high-at-reset-release.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  AD1_i, AD2_i, AD3_i, ISS_RD_i;
  logic        WE3_i, ISS_i, TRIGGER_i;
  logic [31:0] WD3_i;
  logic [31:0] RD1_o, RD2_o, a0_o;
  logic        BUSY1_o, BUSY2_o;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .AD1_i(AD1_i), .AD2_i(AD2_i), .AD3_i(AD3_i),
    .WE3_i(WE3_i), .WD3_i(WD3_i),
    .ISS_i(ISS_i), .ISS_RD_i(ISS_RD_i), .TRIGGER_i(TRIGGER_i),
    .RD1_o(RD1_o), .RD2_o(RD2_o),
    .BUSY1_o(BUSY1_o), .BUSY2_o(BUSY2_o), .a0_o(a0_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  ad1, ad2;
    logic        we3;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        trig;
    logic [31:0] rd1, rd2;
    logic        b1, b2;
    logic [31:0] a0;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic [4:0] a1, logic [4:0] a2,
                              logic we, logic [4:0] a3, logic [31:0] wd,
                              logic is, logic [4:0] ird, logic tg,
                              logic [31:0] e1, logic [31:0] e2,
                              logic eb1, logic eb2, logic [31:0] ea0);
    vec_t v;
    v.rst = r; v.ad1 = a1; v.ad2 = a2; v.we3 = we; v.ad3 = a3; v.wd3 = wd;
    v.iss = is; v.iss_rd = ird; v.trig = tg;
    v.rd1 = e1; v.rd2 = e2; v.b1 = eb1; v.b2 = eb2; v.a0 = ea0;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [4:0] a1, logic [4:0] a2, logic we,
                       logic [4:0] a3, logic [31:0] wd, logic is,
                       logic [4:0] ird, logic tg);
    rst = r; AD1_i = a1; AD2_i = a2; WE3_i = we; AD3_i = a3; WD3_i = wd;
    ISS_i = is; ISS_RD_i = ird; TRIGGER_i = tg;
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rst a1 a2 we a3 wd            is ird tg  rd1           rd2           b1 b2 a0
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,            0, 0, 0, 0,            0,            0, 0, 0);
    vecs[1]  = mk(1, 3, 0, 1, 3, 32'h77,       1, 3, 0, 32'h77,       0,            0, 0, 0);
    vecs[2]  = mk(0, 3, 0, 0, 0, 0,            0, 0, 0, 0,            0,            0, 0, 0);
    vecs[3]  = mk(0, 3, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 0);
    vecs[4]  = mk(0, 3, 0, 1, 0, 32'h1234,     0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 0);
    vecs[5]  = mk(0, 3, 0, 0, 0, 0,            0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 0);
    vecs[6]  = mk(0, 7, 3, 1, 7, 32'h55,       0, 0, 0, 32'h55,       32'hDEADBEEF, 0, 0, 0);
    vecs[7]  = mk(0, 7, 3, 0, 0, 0,            0, 0, 0, 32'h55,       32'hDEADBEEF, 0, 0, 0);
    vecs[8]  = mk(0, 4, 0, 0, 0, 0,            1, 4, 0, 0,            0,            0, 0, 0);
    vecs[9]  = mk(0, 4, 4, 0, 0, 0,            0, 0, 0, 0,            0,            1, 1, 0);
    vecs[10] = mk(0, 4, 0, 1, 4, 32'h44,       0, 0, 0, 32'h44,       0,            0, 0, 0);
    vecs[11] = mk(0, 4, 0, 0, 0, 0,            0, 0, 0, 32'h44,       0,            0, 0, 0);
    vecs[12] = mk(0, 4, 0, 1, 4, 32'h45,       1, 4, 0, 32'h45,       0,            0, 0, 0);
    vecs[13] = mk(0, 4, 0, 0, 0, 0,            1, 0, 0, 32'h45,       0,            1, 0, 0);
    vecs[14] = mk(0, 4, 0, 0, 0, 0,            0, 0, 0, 32'h45,       0,            1, 0, 0);
    vecs[15] = mk(0, 5, 0, 1, 5, 32'h99,       0, 0, 1, 32'h99,       0,            0, 0, 0);
    vecs[16] = mk(0, 5, 0, 0, 0, 0,            0, 0, 1, 32'h1,        0,            0, 0, 0);
    vecs[17] = mk(0, 5, 0, 1, 5, 32'h2,        0, 0, 1, 32'h2,        0,            0, 0, 0);
    vecs[18] = mk(0, 5, 0, 0, 0, 0,            0, 0, 1, 32'h2,        0,            0, 0, 0);
    vecs[19] = mk(0, 5, 0, 0, 0, 0,            0, 0, 1, 32'h2,        0,            0, 0, 0);
    vecs[20] = mk(0, 5, 0, 0, 0, 0,            0, 0, 0, 32'h2,        0,            0, 0, 0);
    vecs[21] = mk(0, 5, 0, 0, 0, 0,            1, 5, 0, 32'h2,        0,            0, 0, 0);
    vecs[22] = mk(0, 5, 0, 0, 0, 0,            0, 0, 1, 32'h2,        0,            1, 0, 0);
    vecs[23] = mk(0, 5, 0, 0, 0, 0,            0, 0, 0, 32'h1,        0,            1, 0, 0);
    vecs[24] = mk(0, 0, 0, 1, 10, 32'hA5,      0, 0, 0, 0,            0,            0, 0, 0);
    vecs[25] = mk(0, 4, 5, 0, 0, 0,            0, 0, 0, 32'h45,       32'h1,        1, 1, 32'hA5);
    vecs[26] = mk(1, 4, 5, 0, 0, 0,            0, 0, 0, 0,            0,            0, 0, 0);
    vecs[27] = mk(0, 10, 0, 0, 0, 0,           0, 0, 0, 0,            0,            0, 0, 0);

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ad1, vecs[i].ad2, vecs[i].we3, vecs[i].ad3,
            vecs[i].wd3, vecs[i].iss, vecs[i].iss_rd, vecs[i].trig);
      #1;
      chk($sformatf("v%0d rd1", i), RD1_o, vecs[i].rd1);
      chk($sformatf("v%0d rd2", i), RD2_o, vecs[i].rd2);
      chk($sformatf("v%0d busy1", i), {31'b0, BUSY1_o}, {31'b0, vecs[i].b1});
      chk($sformatf("v%0d busy2", i), {31'b0, BUSY2_o}, {31'b0, vecs[i].b2});
      chk($sformatf("v%0d a0", i), a0_o, vecs[i].a0);
    end

    // Busy r9 then one reset cycle with a writeback to r9 pending.
    @(negedge clk); drive(0, 9, 0, 0, 0, 0, 1, 9, 0);
    @(negedge clk); drive(0, 9, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("r9 busy after issue", {31'b0, BUSY1_o}, 32'd1);
    @(negedge clk); drive(1, 9, 0, 1, 9, 32'h99, 0, 0, 0); #1;
    chk("r9 busy during rst", {31'b0, BUSY1_o}, 32'd0);
    @(negedge clk); drive(0, 9, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("r9 busy after rst", {31'b0, BUSY1_o}, 32'd0);
    chk("r9 data after rst", RD1_o, 32'd0);
    @(negedge clk); #1;
    chk("r9 data one edge later", RD1_o, 32'd0);

    // Async reset asserted mid-cycle, right after an edge that wrote r10.
    @(negedge clk); drive(0, 0, 0, 1, 10, 32'h5A, 1, 10, 0);
    @(posedge clk); #2;
    drive(0, 10, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("a0 before mid rst", a0_o, 32'h5A);
    chk("busy10 before mid rst", {31'b0, BUSY1_o}, 32'd1);
    rst = 1'b1; #1;
    chk("a0 mid rst", a0_o, 32'd0);
    chk("busy10 mid rst", {31'b0, BUSY1_o}, 32'd0);

    // Trigger already high when reset releases: one write on the first edge.
    @(negedge clk); drive(1, 5, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 5, 0, 0, 0, 0, 0, 0, 1); #1;
    chk("r5 before first edge", RD1_o, 32'd0);
    @(negedge clk); #1;
    chk("r5 after first edge", RD1_o, 32'd1);
    drive(0, 5, 0, 1, 5, 32'h3, 0, 0, 1);
    @(negedge clk); drive(0, 5, 0, 0, 0, 0, 0, 0, 1); #1;
    chk("r5 overwrite with trig held", RD1_o, 32'h3);
    @(negedge clk); #1;
    chk("r5 no second trigger", RD1_o, 32'h3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
